// File: rtl/sm_multi_chan_hold.sv
// CH independent IDLE/S1/S2/ERROR handshake FSMs with a timed ERROR release and per-channel error-entry counters.
// Optional feature macro: SM_ERR_CNT_EN builds the saturating error counters and clr_cnt; otherwise err_cnt reads 0.
module sm_multi_chan_hold #(
  parameter int CH       = 4,
  parameter int ERR_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CH-1:0]       i1,
  input  logic [CH-1:0]       i2,
  input  logic                clr_cnt,
  output logic [CH-1:0]       o1,
  output logic [CH-1:0]       o2,
  output logic [CH-1:0]       err,
  output logic                any_err,
  output logic [CH*CNT_W-1:0] err_cnt
);

  localparam int HOLD_W = (ERR_HOLD < 1) ? 1 : $clog2(ERR_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(ERR_HOLD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S1   = 2'd1,
    ST_S2   = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  state_e              r_state  [CH];
  state_e              w_next   [CH];
  logic [HOLD_W-1:0]   r_hold   [CH];
  logic [HOLD_W-1:0]   w_hold_n [CH];
  logic [CH-1:0]       w_entry;

  // NOTE: sequential state uses non-blocking assignments so every channel samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        r_state[c] <= ST_IDLE;
        r_hold[c]  <= '0;
      end
    end else if (en) begin
      for (int c = 0; c < CH; c++) begin
        r_state[c] <= w_next[c];
        r_hold[c]  <= w_hold_n[c];
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_entry = '0;
    for (int c = 0; c < CH; c++) begin
      w_next[c]   = r_state[c];
      w_hold_n[c] = r_hold[c];
      unique case (r_state[c])
        ST_IDLE: if (i1[c]) w_next[c] = i2[c] ? ST_S1 : ST_ERR;
        ST_S1:   if (i2[c]) w_next[c] = i1[c] ? ST_S2 : ST_ERR;
        ST_S2:   if (!i2[c]) w_next[c] = i1[c] ? ST_IDLE : ST_ERR;
        ST_ERR: begin
          if (r_hold[c] != '0) w_hold_n[c] = r_hold[c] - HOLD_W'(1);
          else if (i1[c])      w_next[c]   = ST_IDLE;
        end
        default: w_next[c] = ST_IDLE;
      endcase
      // Only a fresh entry reloads the hold timer and counts as an error event.
      if (w_next[c] == ST_ERR && r_state[c] != ST_ERR) begin
        w_entry[c]  = 1'b1;
        w_hold_n[c] = HOLD_INIT;
      end
    end
  end

  always_comb begin
    o1  = '0;
    o2  = '0;
    err = '0;
    for (int c = 0; c < CH; c++) begin
      o1[c]  = (r_state[c] == ST_S1) || (r_state[c] == ST_S2);
      o2[c]  = (r_state[c] == ST_S2);
      err[c] = (r_state[c] == ST_ERR);
    end
  end

  assign any_err = |err;

`ifdef SM_ERR_CNT_EN
  logic [CNT_W-1:0] r_cnt [CH];

  // NOTE: the counter array is plain flops, not RAM, so it is reset explicitly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) r_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (clr_cnt)
          r_cnt[c] <= (en && w_entry[c]) ? CNT_W'(1) : '0;
        else if (en && w_entry[c] && r_cnt[c] != '1)
          r_cnt[c] <= r_cnt[c] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    err_cnt = '0;
    for (int c = 0; c < CH; c++) err_cnt[c*CNT_W +: CNT_W] = r_cnt[c];
  end
`else
  logic w_unused_cnt_inputs;
  assign w_unused_cnt_inputs = clr_cnt | (|w_entry);
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_sm_multi_chan_hold.sv
// Directed scenarios plus a randomized run, checked against a cycle-level behavioural model of the channel rules.
module tb_sm_multi_chan_hold;

  localparam int CH       = 4;
  localparam int ERR_HOLD = 8;

`ifdef SM_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_S1 = 1, M_S2 = 2, M_ERR = 3;

  logic          clk = 1'b0;
  logic          rst, en, clr_cnt;
  logic [CH-1:0] i1, i2;

  logic [CH-1:0]   o1_a, o2_a, err_a, o1_b, o2_b, err_b;
  logic            any_a, any_b;
  logic [CH*8-1:0] cnt_a;
  logic [CH*2-1:0] cnt_b;

  sm_multi_chan_hold #(.CH(CH), .ERR_HOLD(ERR_HOLD), .CNT_W(8)) u_dut_w8 (
    .clk(clk), .rst(rst), .en(en), .i1(i1), .i2(i2), .clr_cnt(clr_cnt),
    .o1(o1_a), .o2(o2_a), .err(err_a), .any_err(any_a), .err_cnt(cnt_a)
  );

  sm_multi_chan_hold #(.CH(CH), .ERR_HOLD(ERR_HOLD), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .en(en), .i1(i1), .i2(i2), .clr_cnt(clr_cnt),
    .o1(o1_b), .o2(o2_b), .err(err_b), .any_err(any_b), .err_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  // Reference model: mode per channel, cycles spent in ERROR since entry, entry tallies.
  int m_mode [CH];
  int m_age  [CH];
  int m_cnt8 [CH];
  int m_cnt2 [CH];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      int  nxt;
      bit  a, b, entered;
      a = i1[c];
      b = i2[c];
      nxt = m_mode[c];
      entered = 1'b0;
      if (rst) begin
        m_mode[c] = M_IDLE; m_age[c] = 0; m_cnt8[c] = 0; m_cnt2[c] = 0;
        continue;
      end
      if (en) begin
        if (m_mode[c] == M_IDLE && a)       nxt = b ? M_S1 : M_ERR;
        else if (m_mode[c] == M_S1 && b)    nxt = a ? M_S2 : M_ERR;
        else if (m_mode[c] == M_S2 && !b)   nxt = a ? M_IDLE : M_ERR;
        else if (m_mode[c] == M_ERR) begin
          // Release only once ERR_HOLD edges have elapsed inside ERROR.
          if (m_age[c] >= ERR_HOLD) begin
            if (a) nxt = M_IDLE;
          end else m_age[c]++;
        end
        entered = (nxt == M_ERR) && (m_mode[c] != M_ERR);
        if (entered) m_age[c] = 0;
        m_mode[c] = nxt;
      end
      if (clr_cnt) begin
        m_cnt8[c] = entered ? 1 : 0;
        m_cnt2[c] = entered ? 1 : 0;
      end else if (entered) begin
        if (m_cnt8[c] < 255) m_cnt8[c]++;
        if (m_cnt2[c] < 3)   m_cnt2[c]++;
      end
    end
  endtask

  task automatic check_all();
    logic [CH-1:0]   e_o1, e_o2, e_err;
    logic [CH*8-1:0] e_c8;
    logic [CH*2-1:0] e_c2;
    for (int c = 0; c < CH; c++) begin
      e_o1[c]  = (m_mode[c] == M_S1) || (m_mode[c] == M_S2);
      e_o2[c]  = (m_mode[c] == M_S2);
      e_err[c] = (m_mode[c] == M_ERR);
      e_c8[c*8 +: 8] = CNT_ON ? 8'(m_cnt8[c]) : 8'd0;
      e_c2[c*2 +: 2] = CNT_ON ? 2'(m_cnt2[c]) : 2'd0;
    end
    check("o1",       64'(o1_a),  64'(e_o1));
    check("o2",       64'(o2_a),  64'(e_o2));
    check("err",      64'(err_a), 64'(e_err));
    check("any_err",  64'(any_a), 64'(|e_err));
    check("err_cnt8", 64'(cnt_a), 64'(e_c8));
    check("err_cnt2", 64'(cnt_b), 64'(e_c2));
    check("err_w2",   64'(err_b), 64'(e_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; clr_cnt = 1'b0; i1 = '0; i2 = '0;
    for (int c = 0; c < CH; c++) begin
      m_mode[c] = M_IDLE; m_age[c] = 0; m_cnt8[c] = 0; m_cnt2[c] = 0;
    end

    // 1: reset, then ch0 walks S1 -> S2 -> IDLE
    tick(); tick();
    check("rst_err_cnt", 64'(cnt_a), 64'd0);
    check("rst_o1",      64'(o1_a),  64'd0);
    rst = 1'b0; en = 1'b1;
    tick();
    i1 = 4'b0001; i2 = 4'b0001; tick();
    check("s1_o1", 64'({o1_a[0], o2_a[0]}), 64'b10);
    tick();
    check("s2_o12", 64'({o1_a[0], o2_a[0]}), 64'b11);
    i2 = 4'b0000; tick();
    check("idle_o12", 64'({o1_a[0], o2_a[0], err_a[0]}), 64'b000);

    // 2: ch0 error with i1 held high -> exactly ERR_HOLD+1 cycles of err
    i1 = 4'b0001; i2 = 4'b0000; tick();
    n = err_a[0] ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (err_a[0]) n++;
      else break;
    end
    i1 = '0; tick();
    check("err_len_ch0", 64'(n), 64'(ERR_HOLD + 1));
    check("cnt_ch0", 64'(cnt_a[7:0]), CNT_ON ? 64'd1 : 64'd0);
    check("others_idle", 64'({o1_a[3:1], err_a[3:1]}), 64'd0);

    // 3: five error round-trips on ch1 saturate the 2-bit counter
    for (int r = 0; r < 5; r++) begin
      i1 = 4'b0010; tick();
      for (int k = 0; k < 20 && err_a[1]; k++) tick();
      i1 = '0; tick();
    end
    check("sat_cnt2_ch1", 64'(cnt_b[3:2]),  CNT_ON ? 64'd3 : 64'd0);
    check("cnt8_ch1",     64'(cnt_a[15:8]), CNT_ON ? 64'd5 : 64'd0);
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    check("clr_cnt2", 64'(cnt_b), 64'd0);

    // 4: freeze ch2 in ERROR with 4 hold cycles left
    i1 = 4'b0100; tick();
    i1 = '0; repeat (4) tick();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      i1 = CH'($urandom); i2 = CH'($urandom); tick();
    end
    check("frozen_err2", 64'(err_a[2]), 64'd1);
    en = 1'b1; i1 = 4'b0100; i2 = '0;
    n = 0;
    for (int k = 0; k < 20 && err_a[2]; k++) begin
      tick(); n++;
    end
    check("release_after_en", 64'(n), 64'd5);
    i1 = '0; tick();

    // 5: clear coincides with ch3 entry, then reset mid-ERROR
    clr_cnt = 1'b1; i1 = 4'b1000; tick();
    clr_cnt = 1'b0;
    check("clr_and_entry", 64'(cnt_a), CNT_ON ? 64'h0100_0000 : 64'd0);
    i1 = '0; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_err", 64'({err_a, any_a}), 64'd0);
    check("rst_mid_cnt", 64'(cnt_a), 64'd0);

    // Randomized run against the model
    for (int k = 0; k < 600; k++) begin
      en      = ($urandom_range(0, 9) != 0);
      i1      = CH'($urandom);
      i2      = CH'($urandom);
      clr_cnt = ($urandom_range(0, 39) == 0);
      rst     = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
